// File: rtl/cla_addsub_pipe_if.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe_if
//   Bundles the operand (input) and result (output) valid/ready channels of the
//   pipelined carry-lookahead adder/subtractor.
//
//   Operand channel : in_valid, in_ready, a, b, cin, op
//   Result channel  : out_valid, out_ready, sum, cout, overflow, zero, neg
//
//   master : the environment (drives operands, consumes results)
//   slave  : the adder/subtractor block
// -----------------------------------------------------------------------------
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [1:0]       op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero, neg
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero, neg
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe
//   Two-stage pipelined adder/subtractor built from 4-bit carry-lookahead
//   groups. Stage 1 resolves the low half and the carry into the high half;
//   stage 2 resolves the high half and the result flags.
//
//   op: 00 a+b, 01 a+b+cin, 10 a-b, 11 a-b with borrow (cin = not-borrow)
//
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-low reset
//     bus  : cla_addsub_pipe_if.slave
//            operands  in_valid/in_ready, a, b, cin, op
//            results   out_valid/out_ready, sum, cout, overflow, zero, neg
//
//   WIDTH must be a multiple of 8 (each half is a whole number of 4-bit
//   lookahead groups). Latency is 2 cycles, throughput 1 beat per cycle,
//   capacity 2 beats. in_ready depends combinationally on out_ready.
// -----------------------------------------------------------------------------
module cla_addsub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  cla_addsub_pipe_if.slave bus
);

  localparam int HALF = WIDTH / 2;

  // 4-bit carry-lookahead group: returns {carry_out, sum[3:0]}.
  // Propagate uses OR, which is valid for carry generation; sum bits use XOR.
  function automatic logic [4:0] cla4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic       ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x | y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], x ^ y ^ c[3:0]};
  endfunction

  // Half-width adder: lookahead groups with the group carry rippling
  // between them. Returns {carry_out, sum[HALF-1:0]}.
  function automatic logic [HALF:0] add_half(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic            ci);
    logic [HALF-1:0] s;
    logic            c;
    logic [4:0]      grp;
    s = '0;
    c = ci;
    for (int gi = 0; gi < HALF / 4; gi++) begin
      grp           = cla4(x[gi*4 +: 4], y[gi*4 +: 4], c);
      s[gi*4 +: 4]  = grp[3:0];
      c             = grp[4];
    end
    return {c, s};
  endfunction

  // Carry into the MSB is recovered from the MSB operand bits and sum bit,
  // so signed overflow is that carry XOR the carry out.
  function automatic logic signed_ovf(input logic xm, input logic ym,
                                      input logic sm, input logic co);
    return (xm ^ ym ^ sm) ^ co;
  endfunction

  // Handshake control
  logic adv1, adv2, xfer_in;
  logic vld_p1, vld_p2;

  assign adv2         = !vld_p2 || bus.out_ready;
  assign adv1         = !vld_p1 || adv2;
  assign xfer_in      = bus.in_valid && adv1;
  assign bus.in_ready = adv1;

  // Operand conditioning and low-half add
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [HALF:0]    lo_res;

  always_comb begin
    b_eff  = bus.op[1] ? ~bus.b : bus.b;
    // op 00 -> 0, op 10 -> 1, op x1 -> cin
    c_eff  = bus.op[0] ? bus.cin : bus.op[1];
    lo_res = add_half(bus.a[HALF-1:0], b_eff[HALF-1:0], c_eff);
  end

  // ---- stage 1 boundary: low sum, mid carry, high operand halves ----
  logic [HALF-1:0] sum_lo_p1;
  logic            cmid_p1;
  logic [HALF-1:0] a_hi_p1;
  logic [HALF-1:0] b_hi_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
    end else if (adv1) begin
      vld_p1 <= xfer_in;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer_in) begin
      sum_lo_p1 <= lo_res[HALF-1:0];
      cmid_p1   <= lo_res[HALF];
      a_hi_p1   <= bus.a[WIDTH-1:HALF];
      b_hi_p1   <= b_eff[WIDTH-1:HALF];
    end
  end

  // High-half add and flags
  logic [HALF:0]    hi_res;
  logic [WIDTH-1:0] sum_full;

  always_comb begin
    hi_res   = add_half(a_hi_p1, b_hi_p1, cmid_p1);
    sum_full = {hi_res[HALF-1:0], sum_lo_p1};
  end

  // ---- stage 2 boundary: registers drive the result channel directly ----
  logic [WIDTH-1:0] sum_p2;
  logic             cout_p2, ovf_p2, zero_p2, neg_p2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p2  <= 1'b0;
      sum_p2  <= '0;
      cout_p2 <= 1'b0;
      ovf_p2  <= 1'b0;
      zero_p2 <= 1'b0;
      neg_p2  <= 1'b0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        sum_p2  <= sum_full;
        cout_p2 <= hi_res[HALF];
        ovf_p2  <= signed_ovf(a_hi_p1[HALF-1], b_hi_p1[HALF-1],
                              sum_full[WIDTH-1], hi_res[HALF]);
        zero_p2 <= (sum_full == '0);
        neg_p2  <= sum_full[WIDTH-1];
      end
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.sum       = sum_p2;
  assign bus.cout      = cout_p2;
  assign bus.overflow  = ovf_p2;
  assign bus.zero      = zero_p2;
  assign bus.neg       = neg_p2;

endmodule

// File: doc/cla_addsub_pipe.md
CLA_ADDSUB_PIPE -- requirements
Module: cla_addsub_pipe

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width; SHALL be a multiple of 8 and >= 8.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operand beat offered.
REQ-005 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: cin  input  1  carry-in (add) or not-borrow-in (sub).
REQ-009 Port: op  input  2  00 add, 01 add+cin, 10 sub, 11 sub with borrow.
REQ-010 Port: out_valid  output  1  result beat presented.
REQ-011 Port: out_ready  input  1  downstream consumes the beat.
REQ-012 Port: sum  output  WIDTH  result.
REQ-013 Port: cout  output  1  carry out of MSB; for sub, 1 means no borrow.
REQ-014 Port: overflow  output  1  two's-complement signed overflow.
REQ-015 Port: zero  output  1  sum == 0.
REQ-016 Port: neg  output  1  sum[WIDTH-1].

Function
REQ-017 Effective operation SHALL be sum = a + b_eff + c_eff, with b_eff = op[1] ? ~b : b; c_eff = 0 for op 00, cin for op 01, 1 for op 10, cin for op 11.
REQ-018 Carries SHALL be generated by 4-bit carry-lookahead groups (g = a&b_eff, p = a|b_eff, sum bit = a^b_eff^c), groups rippling group carry.
REQ-019 Pipeline SHALL have two register stages; stage 1 computes low WIDTH/2 bits and mid carry, stage 2 computes high WIDTH/2 bits and all flags.
REQ-020 Stage 1 SHALL register valid1, low sum, mid carry, a high half, b_eff high half.
REQ-021 Stage 2 registers SHALL directly drive out_valid, sum, cout, overflow, zero, neg.
REQ-022 A beat SHALL transfer in when in_valid && in_ready, and out when out_valid && out_ready.
REQ-023 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no backpressure; throughput 1 beat/cycle.
REQ-024 adv2 = !out_valid || out_ready; adv1 = !valid1 || adv2; in_ready = adv1 (combinational path out_ready -> in_ready permitted).
REQ-025 When a stage does not advance, its registers SHALL hold value; while out_valid && !out_ready, sum and all flags SHALL remain stable.
REQ-026 Stage 1 SHALL clear valid1 when it advances with no input transfer; stage 2 likewise clears out_valid.
REQ-027 overflow SHALL equal carry into MSB XOR carry out of MSB.
REQ-028 Capacity SHALL be 2 beats; order SHALL be preserved; no beat dropped or duplicated.
REQ-029 Data fields of an invalid stage are don't-care, but flags SHALL be consistent with sum whenever out_valid=1.

Reset
REQ-030 On rst low, valid1 and out_valid SHALL clear immediately (asynchronously); sum, cout, overflow, zero, neg SHALL be 0.
REQ-031 in_ready SHALL be 1 while in reset-released idle; in-flight beats at reset are discarded.
REQ-032 Reset deassertion SHALL be sampled on clk; first transfer possible on the first edge after release.

Verification (WIDTH=16)
REQ-033 a=0x7FFF b=0x0001 op=00, out_ready=1 -> after 2 cycles sum=0x8000 cout=0 overflow=1 neg=1 zero=0.
REQ-034 a=0x00FF b=0x0001 op=00 (cross-stage carry) -> sum=0x0100 cout=0; a=0xFFFF b=0x0001 -> sum=0x0000 cout=1 zero=1 overflow=0.
REQ-035 a=0x0005 b=0x0005 op=10 -> sum=0x0000 cout=1 zero=1; a=0x0003 b=0x0005 op=11 cin=0 -> sum=0xFFFD cout=0 neg=1.
REQ-036 Back-to-back 3 beats with out_ready=0 -> 2 accepted, in_ready=0 on third, outputs stable; release out_ready -> beats emerge in order, one per cycle.
REQ-037 rst low mid-stream with 2 beats in flight -> out_valid=0 and outputs 0 same cycle, no stale beat after release.
REQ-038 Random constrained stimulus against reference model a+b_eff+c_eff with random in_valid/out_ready -> all beats match, order kept.
